// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue sitting between instruction memory and
// decode. A fetch PC register drives imem_addr; each accepted word is stored
// as a {pc, instr} pair in a circular buffer of DEPTH entries. The head entry
// is presented to decode with a valid/ready handshake.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A
// transfer happens on a rising edge where both are 1. Once out_valid is
// raised, out_pc/out_instr hold until that transfer, unless redirect or
// reset_n flushes the queue.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present the memory word
// straight to decode while the queue is empty. This removes the one-cycle
// fetch-to-decode latency. The default build leaves the macro undefined and
// always goes through the queue.
//
// There is no FSM here. The occupancy (count), the fetch PC (imem_addr) and
// the head entry are all visible on ports for checkers.

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_data,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Architectural state
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Entry storage (no reset needed; count_q qualifies every read)
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   // Per-cycle control
   logic q_valid;     // queue holds at least one entry
   logic byp_active;  // empty-queue bypass is presenting the memory word
   logic pop;         // handshake completes this cycle
   logic pop_q;       // handshake consumes a stored entry
   logic byp_take;    // handshake consumes the bypassed word directly
   logic full;
   logic advance;     // fetch_pc moves forward by one word
   logic push;        // memory word is written at the tail

   // Only word-aligned redirect targets are meaningful; the low bits are dropped.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign imem_addr = fetch_pc_q;
   assign count     = count_q;

   // Decode-side view: head entry, or the memory word itself via the bypass.
   always_comb begin
      q_valid    = (count_q != '0);
      byp_active = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp_active = reset_n && !q_valid && !redirect;
`endif
      out_valid  = reset_n && (q_valid || byp_active);
      out_pc     = '0;
      out_instr  = '0;
      if (reset_n) begin
         if (byp_active) begin
            out_pc    = fetch_pc_q;
            out_instr = imem_data;
         end else begin
            out_pc    = pc_mem_q[rd_ptr_q];
            out_instr = instr_mem_q[rd_ptr_q];
         end
      end
   end

   // Next-state: redirect flushes ahead of push; pop and push may share a cycle.
   always_comb begin
      full     = (count_q == DEPTH_C);
      pop      = out_valid && out_ready;
      pop_q    = pop && q_valid;
      byp_take = pop && byp_active;
      advance  = reset_n && !redirect && (!full || pop);
      push     = advance && !byp_take;

      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (advance) fetch_pc_d = fetch_pc_q + 32'd4;
         if (pop_q)   rd_ptr_d   = rd_ptr_q + 1'b1;
         if (push)    wr_ptr_d   = wr_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop_q);
      end
   end

   // Pointer, count and fetch PC registers; reset empties the queue at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Tail write of the {pc, instr} pair.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue, checked
// against a queue-based reference model of the fetch/decode behaviour.
// Define FETCH_QUEUE_BYPASS_EN for both files to exercise the bypass build.

module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                    clk;
   logic                    reset_n;
   logic [31:0]             imem_addr;
   logic [31:0]             imem_data;
   logic                    redirect;
   logic [31:0]             redirect_pc;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_pc;
   logic [31:0]             out_instr;
   logic [$clog2(DEPTH):0]  count;

   int checks = 0;
   int errors = 0;

   // Reference model: expected queue contents and fetch PC
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_instr_q[$];
   logic [31:0] m_pc;
   bit          byp_en;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .count       (count)
   );

   // Instruction memory: a fixed address-dependent pattern
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   assign imem_data = imem_word(imem_addr);

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: apply inputs at the falling edge, compare outputs with the
   // model, then advance the model to where the next rising edge takes the DUT.
   task automatic cycle(input logic r, input logic [31:0] rpc, input logic rdy);
      int   n;
      logic ev;
      logic pop;
      @(negedge clk);
      redirect    = r;
      redirect_pc = rpc;
      out_ready   = rdy;
      #1;
      n  = exp_pc_q.size();
      ev = (n > 0) || (byp_en && !r);
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("count", 32'(count), 32'(n));
      check_eq("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
         if (n > 0) begin
            check_eq("out_pc", out_pc, exp_pc_q[0]);
            check_eq("out_instr", out_instr, exp_instr_q[0]);
         end else begin
            check_eq("byp_pc", out_pc, m_pc);
            check_eq("byp_instr", out_instr, imem_word(m_pc));
         end
      end
      pop = ev && rdy;
      if (r) begin
         exp_pc_q.delete();
         exp_instr_q.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else if (n < DEPTH || pop) begin
         if (pop && n > 0) begin
            void'(exp_pc_q.pop_front());
            void'(exp_instr_q.pop_front());
         end
         if (!(pop && n == 0)) begin
            exp_pc_q.push_back(m_pc);
            exp_instr_q.push_back(imem_word(m_pc));
         end
         m_pc = m_pc + 32'd4;
      end
   endtask

   // Move just past the next rising edge to look at registered state
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_pc_q.delete();
      exp_instr_q.delete();
      m_pc = RESET_PC;
   endtask

   initial begin
`ifdef FETCH_QUEUE_BYPASS_EN
      byp_en = 1'b1;
`else
      byp_en = 1'b0;
`endif
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      model_reset();
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_addr", imem_addr, RESET_PC);
      check_eq("rst_pc", out_pc, 32'd0);
      check_eq("rst_instr", out_instr, 32'd0);

      // Release and stream with decode always ready
      settle();
      settle();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

      // Fill from empty with decode stalled
      cycle(1'b1, 32'd0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0);
      settle();
      check_eq("full_count", 32'(count), 32'd4);
      check_eq("full_addr", imem_addr, 32'h10);
      check_eq("full_pc", out_pc, 32'h0);

      // One pop while full pushes the next word
      cycle(1'b0, 32'd0, 1'b1);
      settle();
      check_eq("popfull_count", 32'(count), 32'd4);
      check_eq("popfull_addr", imem_addr, 32'h14);
      check_eq("popfull_pc", out_pc, 32'h4);

      // Redirect with three entries queued, to an unaligned target
      cycle(1'b1, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'h103, 1'b0);
      settle();
      check_eq("redir_count", 32'(count), 32'd0);
      check_eq("redir_addr", imem_addr, 32'h100);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);

      // Reset mid-stream with two entries queued
      cycle(1'b1, 32'h40, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      settle();
      check_eq("pre_rst_count", 32'(count), 32'd2);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_count", 32'(count), 32'd0);
      check_eq("mid_rst_addr", imem_addr, RESET_PC);
      check_eq("mid_rst_pc", out_pc, 32'd0);
      settle();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);

      // Fetch PC wraps at the top of the address space
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);

      // Random traffic: occasional redirects, bursty decode stalls
      for (int i = 0; i < 400; i++) begin
         logic       r;
         logic       rdy;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         if (i % 100 < 50) rdy = ($urandom_range(0, 3) != 0);
         else              rdy = ($urandom_range(0, 3) == 0);
         cycle(r, rpc, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, number of queue entries (power of two, at least 2).
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port imem_addr  output  32  current fetch PC driven to instruction memory.
REQ-006 The module SHALL have port imem_data  input  32  instruction word at imem_addr, valid combinationally in the same cycle.
REQ-007 The module SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-008 The module SHALL have port redirect_pc  input  32  new fetch address when redirect=1.
REQ-009 The module SHALL have port out_valid  output  1  head entry available to decode (IF/ID register).
REQ-010 The module SHALL have port out_ready  input  1  decode accepts the head entry this cycle.
REQ-011 The module SHALL have port out_pc  output  32  PC of the head entry.
REQ-012 The module SHALL have port out_instr  output  32  instruction of the head entry.
REQ-013 The module SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 The queue SHALL be a circular buffer of {pc, instr} pairs with read/write pointers wrapping modulo DEPTH.
REQ-015 imem_addr SHALL equal the internal fetch_pc register at all times.
REQ-016 Push: when redirect=0 and (count<DEPTH or a pop occurs that cycle), it SHALL write {fetch_pc, imem_data} at the tail and increment fetch_pc by 4.
REQ-017 Pop: a transfer SHALL occur exactly when out_valid=1 and out_ready=1; the head advances by one.
REQ-018 out_valid SHALL be 1 iff count>0 (bypass excepted, REQ-031); out_pc/out_instr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; full queue with pop SHALL still push.
REQ-020 Full (count=DEPTH) with no pop: no push, fetch_pc held, imem_addr stable.
REQ-021 Redirect SHALL have priority over push: a pop in the same cycle completes; all remaining entries are discarded (count becomes 0), fetch_pc loads {redirect_pc[31:2], 2'b00}, nothing is pushed.
REQ-022 Without bypass, the first entry after a redirect SHALL appear on out_valid one cycle after the redirect cycle.
REQ-023 fetch_pc arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).
REQ-024 count SHALL update in the same edge as pushes, pops and flushes.

Reset
REQ-025 reset_n=0 SHALL asynchronously set fetch_pc=RESET_PC, pointers=0, count=0, out_valid=0.
REQ-026 While reset_n=0, out_pc and out_instr SHALL read 0 and no push or pop occurs.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately; no partial state survives.
REQ-028 After reset_n deasserts, the first push SHALL occur at the first rising edge with reset_n=1.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN SHALL control the empty-queue bypass path.
REQ-030 Without FETCH_QUEUE_BYPASS_EN, minimum fetch-to-decode latency SHALL be one cycle.
REQ-031 With FETCH_QUEUE_BYPASS_EN, when count=0, redirect=0 and reset_n=1: out_valid=1, out_pc=fetch_pc, out_instr=imem_data combinationally; if out_ready=1 the word is consumed without being written, fetch_pc+=4; if out_ready=0 it is pushed as normal.

Verification
REQ-032 Reset release, RESET_PC=0, out_ready=1 -> out_pc sequence 0,4,8,... one per cycle; first valid one cycle after release (same cycle with bypass).
REQ-033 out_ready=0 for 6 cycles from empty, DEPTH=4 -> count 1,2,3,4,4,4; imem_addr frozen at 0x10; out_pc stays 0x0.
REQ-034 Full queue, out_ready=1 for 1 cycle -> head 0x0 popped, entry 0x10 pushed, count stays 4, imem_addr becomes 0x14.
REQ-035 count=3, redirect=1 with redirect_pc=0x103 -> count 0 next cycle, imem_addr 0x100, next out_pc 0x100.
REQ-036 reset_n pulsed low mid-stream with count=2 -> out_valid drops immediately, count 0, imem_addr=RESET_PC.
REQ-037 redirect_pc=0xFFFF_FFFC, out_ready=1 -> out_pc 0xFFFF_FFFC then 0x0000_0000.
